pc_fetch_unit: RTL

//  Program counter and fetch sequencer placed directly upstream of the instruction ROM in the single-cycle RISC-V core.
//  - Holds the byte PC and drives the ROM word index.
//  - Selects the next PC from sequential, branch, jal or jalr sources.
//  - Provides run/pause/single-step/halt control from board switches.
//  - Outputs the link value (PC+4) for the RF write-back mux.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/step_sync.sv | 30 +++
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM encoding, next-PC source select.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        PAUSE = 3'd1,
        HALT  = 3'd2,
        FAULT = 3'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        BR   = 2'd1,
        JAL  = 2'd2,
        JALR = 2'd3
    } npc_src_e;

    // Fixed priority: jalr > jal > taken branch > fall-through.
    function automatic npc_src_e sel_npc_src(input logic is_jalr,
                                             input logic is_jal,
                                             input logic is_br);
        if (is_jalr)     return JALR;
        else if (is_jal) return JAL;
        else if (is_br)  return BR;
        else             return SEQ;
    endfunction

endpackage

// File: rtl/step_sync.sv
// Step button conditioner: 2-FF synchroniser then rising-edge detect to a 1-clk pulse.
// Latency: pulse asserts 2-3 clk after the asynchronous edge.
// Backpressure: none; a pulse is produced once per rising edge regardless of consumer.
// Ports: clk, rstn (async active-low), async_in (raw button), rise_pulse (1-clk pulse).
module step_sync (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta_q;
    logic sync_q;
    logic sync_d_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            sync_d_q <= 1'b0;
        end else begin
            meta_q   <= async_in;
            sync_q   <= meta_q;
            sync_d_q <= sync_q;
        end
    end

    assign rise_pulse = sync_q & ~sync_d_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer feeding the instruction ROM, with run/pause/step/halt control.
// Latency: pc commits on the clk edge where cpu_tick=1; rom_addr/pc_plus4 are combinational from pc.
// Backpressure: pause level holds the PC (wins over cpu_tick); HALT/FAULT absorb until reset.
// Ports: clk, rstn, cpu_tick, pause, step_btn, br_taken, jal, jalr, imm, rs1_val in;
//        pc, pc_plus4, rom_addr, state, halted, fault, instr_cnt out.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int ROM_AW    = 6,
    parameter int INSTR_NUM = 12,
    parameter int RESET_PC  = 0,
    parameter bit WRAP      = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_tick,
    input  logic              pause,
    input  logic              step_btn,
    input  logic              br_taken,
    input  logic              jal,
    input  logic              jalr,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1_val,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       instr_cnt
);

    localparam logic [XLEN-1:0] RST_PC   = XLEN'(RESET_PC);
    localparam logic [XLEN-1:0] LAST_IDX = XLEN'(INSTR_NUM);
    localparam logic [XLEN-1:0] CLR_B0   = {{(XLEN-1){1'b1}}, 1'b0};

    fetch_state_e st_q, st_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [31:0]     cnt_q, cnt_nxt;
    logic            fault_q, fault_nxt;
    logic            pend_q, pend_nxt;

    logic            step_pulse;
    npc_src_e        src;
    logic [XLEN-1:0] npc;
    logic            misaligned;
    logic            past_end;
    logic            commit_req;

    // Outcome of a commit attempt, applied only when the FSM decides to commit.
    fetch_state_e    c_st;
    logic [XLEN-1:0] c_pc;
    logic [31:0]     c_cnt;
    logic            c_fault;

    step_sync u_step_sync (
        .clk        (clk),
        .rstn       (rstn),
        .async_in   (step_btn),
        .rise_pulse (step_pulse)
    );

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign rom_addr  = pc_q[ROM_AW+1:2];
    assign state     = st_q;
    assign halted    = (st_q == HALT);
    assign fault     = fault_q;
    assign instr_cnt = cnt_q;

    always_comb begin
        src = sel_npc_src(jalr, jal, br_taken);
        case (src)
            JALR:    npc = (rs1_val + imm) & CLR_B0;
            JAL, BR: npc = pc_q + imm;
            default: npc = pc_q + XLEN'(4);
        endcase
        misaligned = npc[1];
        past_end   = (npc >> 2) >= LAST_IDX;
    end

    // A misaligned target blocks the whole commit; an out-of-range target still retires
    // the current instruction but either parks the PC (HALT) or restarts the program.
    always_comb begin
        c_st    = st_q;
        c_pc    = pc_q;
        c_cnt   = cnt_q;
        c_fault = fault_q;
        if (misaligned) begin
            c_st    = FAULT;
            c_fault = 1'b1;
        end else if (past_end) begin
            c_cnt = cnt_q + 32'd1;
            if (WRAP) c_pc = RST_PC;
            else      c_st = HALT;
        end else begin
            c_pc  = npc;
            c_cnt = cnt_q + 32'd1;
        end
    end

    assign commit_req = cpu_tick &
                        (((st_q == RUN) & ~pause) | ((st_q == PAUSE) & pause & pend_q));

    always_comb begin
        st_nxt    = st_q;
        pc_nxt    = pc_q;
        cnt_nxt   = cnt_q;
        fault_nxt = fault_q;
        pend_nxt  = pend_q;
        case (st_q)
            RUN: begin
                pend_nxt = 1'b0;               // steps are meaningless while running
                if (pause) begin
                    st_nxt = PAUSE;
                end else if (commit_req) begin
                    st_nxt    = c_st;
                    pc_nxt    = c_pc;
                    cnt_nxt   = c_cnt;
                    fault_nxt = c_fault;
                end
            end
            PAUSE: begin
                if (!pause) begin
                    st_nxt   = RUN;
                    pend_nxt = 1'b0;
                end else if (commit_req) begin
                    st_nxt    = (c_st == RUN) ? PAUSE : c_st;
                    pc_nxt    = c_pc;
                    cnt_nxt   = c_cnt;
                    fault_nxt = c_fault;
                    // A fresh edge coincident with the consuming tick re-arms for the next tick.
                    pend_nxt  = step_pulse;
                end else if (step_pulse) begin
                    pend_nxt = 1'b1;
                end
            end
            default: begin
                pend_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= RUN;
            pc_q    <= RST_PC;
            cnt_q   <= 32'd0;
            fault_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            st_q    <= st_nxt;
            pc_q    <= pc_nxt;
            cnt_q   <= cnt_nxt;
            fault_q <= fault_nxt;
            pend_q  <= pend_nxt;
        end
    end

endmodule
